// File: rtl/scrypt_nonce_sweeper.sv
// Nonce sweeper for one scrypt_new core: launches one computation per nonce,
// compares each hash with the job target and reports hits and end-of-job status.
module scrypt_nonce_sweeper #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int GAP_CYCLES     = 1,
  parameter bit STOP_ON_FOUND  = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_start,
  input  logic         job_abort,
  input  logic [639:0] job_header,
  input  logic [255:0] job_target,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_count,
  output logic         core_init,
  output logic [639:0] core_in,
  input  logic [255:0] core_out,
  input  logic         core_valid,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  nonces_done,
  output logic         status_timeout,
  output logic         status_aborted
);
  // state  | meaning
  // IDLE   | waiting for job_start
  // LAUNCH | first cycle of core_init high
  // WAIT   | core computing; watch core_valid and the timeout
  // CHECK  | compare hash_q against the target
  // GAP    | core_init held low before the next launch
  // DONE   | job over; done pulses in the following cycle
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_GAP, S_DONE
  } state_t;

  localparam logic [31:0] WAIT_LOAD  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD   = 32'(GAP_CYCLES - 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t         state, state_nxt;
  logic [607:0]   header_q;
  logic [255:0]   target_q, hash_q;
  logic [31:0]    nonce_q, remaining_q, wait_cnt, gap_cnt;
  logic           active, abort_now, timed_out, hit, check_ok;
  logic           unused_hdr_bits;

  // the low header word is replaced by the nonce, so it is never stored
  assign unused_hdr_bits = ^job_header[31:0];

  assign active    = (state == S_LAUNCH) || (state == S_WAIT) ||
                     (state == S_CHECK)  || (state == S_GAP);
  assign abort_now = active && job_abort;
  assign timed_out = TIMEOUT_EN && (wait_cnt == '0);
  assign hit       = (hash_q <= target_q);
  assign check_ok  = (state == S_CHECK) && !job_abort;

  assign core_init = (state == S_LAUNCH) || (state == S_WAIT);
  assign busy      = (state != S_IDLE);
  assign core_in   = {header_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (job_start) state_nxt = (job_nonce_count == '0) ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_valid)     state_nxt = S_CHECK;
        else if (timed_out) state_nxt = S_DONE;
      end
      S_CHECK: begin
        if ((hit && STOP_ON_FOUND) || (remaining_q == 32'd1)) state_nxt = S_DONE;
        else                                                  state_nxt = S_GAP;
      end
      S_GAP:    if (gap_cnt == '0) state_nxt = S_LAUNCH;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      header_q       <= '0;
      target_q       <= '0;
      hash_q         <= '0;
      nonce_q        <= '0;
      remaining_q    <= '0;
      wait_cnt       <= '0;
      gap_cnt        <= '0;
      done           <= 1'b0;
      found          <= 1'b0;
      found_nonce    <= '0;
      found_hash     <= '0;
      nonces_done    <= '0;
      status_timeout <= 1'b0;
      status_aborted <= 1'b0;
    end else begin
      found <= 1'b0;
      done  <= (state == S_DONE);
      if ((state == S_IDLE) && job_start) begin
        header_q       <= job_header[639:32];
        target_q       <= job_target;
        nonce_q        <= job_nonce_start;
        remaining_q    <= job_nonce_count;
        nonces_done    <= '0;
        status_timeout <= 1'b0;
        status_aborted <= 1'b0;
      end
      if (abort_now) status_aborted <= 1'b1;
      if (state == S_LAUNCH) wait_cnt <= WAIT_LOAD;
      // an abort discards any result arriving in the same cycle
      if ((state == S_WAIT) && !job_abort) begin
        if (core_valid)     hash_q <= core_out;
        else if (timed_out) status_timeout <= 1'b1;
        else                wait_cnt <= wait_cnt - 32'd1;
      end
      if (check_ok) begin
        nonces_done <= nonces_done + 32'd1;
        if (hit) begin
          found       <= 1'b1;
          found_nonce <= nonce_q;
          found_hash  <= hash_q;
        end
        if (state_nxt == S_GAP) begin
          remaining_q <= remaining_q - 32'd1;
          nonce_q     <= nonce_q + 32'd1;
          gap_cnt     <= GAP_LOAD;
        end
      end
      if (state == S_GAP) gap_cnt <= gap_cnt - 32'd1;
    end
  end
endmodule

// File: tb/tb_scrypt_nonce_sweeper.sv
// Self-checking bench for scrypt_nonce_sweeper with a fixed-latency core model
// and scoreboards for launches and hits.
module tb_scrypt_nonce_sweeper;
  localparam int LAT = 50;
  localparam int TMO = 100;
  localparam int GAP = 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_start, job_abort;
  logic [639:0] job_header;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start, job_nonce_count;
  logic         core_init;
  logic [639:0] core_in;
  logic [255:0] core_out;
  logic         core_valid;
  logic         busy, done, found;
  logic [31:0]  found_nonce, nonces_done;
  logic [255:0] found_hash;
  logic         status_timeout, status_aborted;

  logic         model_valid = 1'b0;
  logic         inject_valid = 1'b0;
  logic         model_respond = 1'b0;
  logic [255:0] model_hash = '0;
  int           lat_cnt = 0;

  int checks = 0;
  int errors = 0;
  logic [639:0] exp_launch_q[$];
  logic [287:0] exp_found_q[$];
  logic [639:0] mon_exp;
  logic [287:0] mon_fexp;
  int launches = 0, found_cnt = 0, done_cnt = 0, low_run = 0;
  logic prev_init = 1'b0;

  assign core_valid = model_valid | inject_valid;
  assign core_out   = model_hash;

  always #5 clk = ~clk;

  scrypt_nonce_sweeper #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP), .STOP_ON_FOUND(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .job_start(job_start), .job_abort(job_abort),
    .job_header(job_header), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_count(job_nonce_count),
    .core_init(core_init), .core_in(core_in), .core_out(core_out), .core_valid(core_valid),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .found_hash(found_hash), .nonces_done(nonces_done),
    .status_timeout(status_timeout), .status_aborted(status_aborted)
  );

  function automatic logic [639:0] launch_word(input logic [639:0] hdr, input logic [31:0] n);
    logic [31:0] le;
    le = {<<8{n}};
    return {hdr[639:32], le};
  endfunction

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[i*32 +: 32] = $urandom();
    return h;
  endfunction

  // core model: result LAT cycles after core_init rises, only while it stays high
  always @(negedge clk) begin
    if (!core_init) begin
      lat_cnt     = 0;
      model_valid = 1'b0;
    end else begin
      lat_cnt++;
      model_valid = model_respond && (lat_cnt == LAT);
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (core_init && !prev_init) begin
        launches++;
        checks++;
        if (exp_launch_q.size() == 0) begin
          errors++;
          $display("FAIL launch_unexpected core_in[31:0]=%h", core_in[31:0]);
        end else begin
          mon_exp = exp_launch_q.pop_front();
          if (core_in !== mon_exp) begin
            errors++;
            $display("FAIL launch_core_in got %h want %h", core_in, mon_exp);
          end
        end
        if (launches > 1) begin
          checks++;
          if (low_run < GAP + 1) begin
            errors++;
            $display("FAIL relaunch_gap got %0d low cycles want >= %0d", low_run, GAP + 1);
          end
        end
      end
      if (found) begin
        found_cnt++;
        checks++;
        if (exp_found_q.size() == 0) begin
          errors++;
          $display("FAIL found_unexpected nonce=%h hash=%h", found_nonce, found_hash);
        end else begin
          mon_fexp = exp_found_q.pop_front();
          if ({found_nonce, found_hash} !== mon_fexp) begin
            errors++;
            $display("FAIL found_value got nonce=%h hash=%h want nonce=%h hash=%h",
                     found_nonce, found_hash, mon_fexp[287:256], mon_fexp[255:0]);
          end
        end
      end
      if (done) done_cnt++;
      if (!core_init) low_run++;
      else            low_run = 0;
    end
    prev_init = core_init;
  end

  task automatic reset_counters();
    launches = 0; found_cnt = 0; done_cnt = 0; low_run = 0;
  endtask

  task automatic start_job(input logic [639:0] h, input logic [255:0] t,
                           input logic [31:0] s, input logic [31:0] c);
    @(negedge clk);
    job_header = h; job_target = t; job_nonce_start = s; job_nonce_count = c;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  // returns the negedge index (1 = first negedge after the sampling edge) or -1
  task automatic wait_done(input int budget, output int n);
    n = 1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) n = -1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({core_init, busy, done, found, found_nonce, found_hash, nonces_done,
           status_timeout, status_aborted, core_in} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: init=%b busy=%b done=%b found=%b nd=%h want all 0",
                 i, core_init, busy, done, found, nonces_done);
      end
      job_start = 1'($urandom()); job_abort = 1'($urandom());
      job_header = rand_hdr(); job_target = {8{$urandom()}};
      job_nonce_start = $urandom(); job_nonce_count = $urandom();
    end
    job_start = 1'b0; job_abort = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hit();
    logic [639:0] h;
    int n, k;
    h = rand_hdr();
    reset_counters();
    model_respond = 1'b1; model_hash = 256'h1;
    exp_launch_q.push_back(launch_word(h, 32'h10));
    exp_found_q.push_back({32'h10, 256'h1});
    start_job(h, {256{1'b1}}, 32'h10, 32'd3);
    k = 0;
    while (!core_init && k < 10) begin @(negedge clk); k++; end
    checks++;
    if (core_in[31:0] !== 32'h10000000) begin
      errors++;
      $display("FAIL hit_nonce_field got %h want 10000000", core_in[31:0]);
    end
    wait_done(300, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL hit_done got no done want done"); end
    checks++;
    if (found_cnt !== 1) begin errors++; $display("FAIL hit_found_count got %0d want 1", found_cnt); end
    checks++;
    if (nonces_done !== 32'd1) begin errors++; $display("FAIL hit_nonces_done got %0d want 1", nonces_done); end
    checks++;
    if (launches !== 1) begin errors++; $display("FAIL hit_launches got %0d want 1", launches); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL hit_done_count got %0d want 1", done_cnt); end
    checks++;
    if (found_nonce !== 32'h10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hit_final got nonce=%h busy=%b want nonce=10 busy=0", found_nonce, busy);
    end
  endtask

  task automatic test_miss_wrap();
    logic [639:0] h;
    logic [31:0] s;
    int n;
    h = rand_hdr();
    s = 32'hFFFFFFFE;
    reset_counters();
    model_respond = 1'b1; model_hash = 256'h5;
    for (int i = 0; i < 4; i++) exp_launch_q.push_back(launch_word(h, s + 32'(i)));
    start_job(h, '0, s, 32'd4);
    wait_done(600, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL miss_done got no done want done"); end
    checks++;
    if (found_cnt !== 0) begin errors++; $display("FAIL miss_found got %0d want 0", found_cnt); end
    checks++;
    if (nonces_done !== 32'd4) begin errors++; $display("FAIL miss_nonces_done got %0d want 4", nonces_done); end
    checks++;
    if (launches !== 4) begin errors++; $display("FAIL miss_launches got %0d want 4", launches); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL miss_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    logic [639:0] h;
    int n, k;
    h = rand_hdr();
    reset_counters();
    model_respond = 1'b1; model_hash = 256'h5;
    exp_launch_q.push_back(launch_word(h, 32'h20));
    exp_launch_q.push_back(launch_word(h, 32'h21));
    start_job(h, '0, 32'h20, 32'd5);
    k = 0;
    while (!(core_init && nonces_done == 32'd1) && k < 300) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    job_abort = 1'b1; inject_valid = 1'b1; model_hash = '0;
    @(negedge clk);
    job_abort = 1'b0; inject_valid = 1'b0;
    checks++;
    if (core_init !== 1'b0 || status_aborted !== 1'b1) begin
      errors++;
      $display("FAIL abort_response got init=%b aborted=%b want init=0 aborted=1", core_init, status_aborted);
    end
    wait_done(10, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL abort_done got no done want done"); end
    checks++;
    if (found_cnt !== 0) begin errors++; $display("FAIL abort_found got %0d want 0", found_cnt); end
    checks++;
    if (nonces_done !== 32'd1) begin errors++; $display("FAIL abort_nonces_done got %0d want 1", nonces_done); end
    checks++;
    if (status_aborted !== 1'b1 || status_timeout !== 1'b0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_status got aborted=%b timeout=%b dones=%0d want 1 0 1",
               status_aborted, status_timeout, done_cnt);
    end
    model_hash = 256'h5;
  endtask

  task automatic test_timeout();
    logic [639:0] h;
    int n;
    h = rand_hdr();
    reset_counters();
    model_respond = 1'b0;
    exp_launch_q.push_back(launch_word(h, 32'h40));
    start_job(h, {256{1'b1}}, 32'h40, 32'd2);
    wait_done(200, n);
    checks++;
    if (n < TMO || n > TMO + 3) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles want %0d..%0d", n, TMO, TMO + 3);
    end
    checks++;
    if (status_timeout !== 1'b1 || status_aborted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_status got timeout=%b aborted=%b want 1 0", status_timeout, status_aborted);
    end
    checks++;
    if (nonces_done !== 32'd0 || found_cnt !== 0 || launches !== 1) begin
      errors++;
      $display("FAIL timeout_counts got nd=%0d found=%0d launches=%0d want 0 0 1",
               nonces_done, found_cnt, launches);
    end
  endtask

  task automatic test_count_zero();
    int n;
    reset_counters();
    model_respond = 1'b1;
    start_job(rand_hdr(), {256{1'b1}}, 32'h55, 32'd0);
    wait_done(10, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL count0_latency got %0d want 2", n); end
    checks++;
    if (launches !== 0 || nonces_done !== 32'd0 || status_timeout !== 1'b0) begin
      errors++;
      $display("FAIL count0_state got launches=%0d nd=%0d timeout=%b want 0 0 0",
               launches, nonces_done, status_timeout);
    end
  endtask

  task automatic test_back_to_back();
    logic [639:0] h;
    int n, k;
    h = rand_hdr();
    reset_counters();
    model_respond = 1'b1; model_hash = 256'h5;
    exp_launch_q.push_back(launch_word(h, 32'h100));
    exp_launch_q.push_back(launch_word(h, 32'h101));
    start_job(h, '0, 32'h100, 32'd2);
    k = 0;
    while (!core_init && k < 10) begin @(negedge clk); k++; end
    job_header = rand_hdr(); job_nonce_start = 32'h999; job_nonce_count = 32'd9;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    wait_done(400, n);
    checks++;
    if (n < 0) begin errors++; $display("FAIL ignore_done got no done want done"); end
    checks++;
    if (nonces_done !== 32'd2 || launches !== 2 || done_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_counts got nd=%0d launches=%0d dones=%0d want 2 2 1",
               nonces_done, launches, done_cnt);
    end
  endtask

  initial begin
    reset_n = 1'b0; job_start = 1'b0; job_abort = 1'b0;
    job_header = '0; job_target = '0; job_nonce_start = '0; job_nonce_count = '0;
    test_reset();
    test_hit();
    test_miss_wrap();
    test_abort();
    test_timeout();
    test_count_zero();
    test_back_to_back();
    checks++;
    if (exp_launch_q.size() != 0 || exp_found_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d launches %0d hits pending want 0 0",
               exp_launch_q.size(), exp_found_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
